// File: rtl/msg_sched_pkg.sv
// msg_sched_pkg: FSM states, message lengths and ASCII tables
// shared by the scheduler and its character ROM.
package msg_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int unsigned LEN_GUAT = 9;
  localparam int unsigned LEN_QUET = 7;

  // Entry 0 is the first character; unused tail is zero-padded
  // so a 4-bit index always lands inside the table.
  localparam logic [15:0][7:0] GUAT_C = {
    {7{8'h00}},
    8'h61, 8'h6C, 8'h61, 8'h6D, 8'h65,
    8'h74, 8'h61, 8'h75, 8'h47
  };

  localparam logic [15:0][7:0] QUET_C = {
    {9{8'h00}},
    8'h6C, 8'h61, 8'h7A, 8'h74,
    8'h65, 8'h75, 8'h51
  };

  // sel 00/11 pick the long message, 01/10 the short one.
  function automatic logic is_guat(input logic [1:0] sel);
    return sel[1] == sel[0];
  endfunction

  function automatic logic [3:0] last_idx(input logic [1:0] sel);
    return is_guat(sel) ? 4'(LEN_GUAT - 1) : 4'(LEN_QUET - 1);
  endfunction

endpackage

// File: rtl/msg_sched_if.sv
// msg_sched_if: requester / character-stream bundle.
// master drives en, req, sel_*, char_ready; slave drives the rest.
interface msg_sched_if;
  logic       en;
  logic [1:0] req;
  logic [1:0] sel_0;
  logic [1:0] sel_1;
  logic       char_ready;
  logic [7:0] char_out;
  logic       char_valid;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       busy;

  modport master (
    output en, req, sel_0, sel_1, char_ready,
    input  char_out, char_valid, gnt, done, busy
  );

  modport slave (
    input  en, req, sel_0, sel_1, char_ready,
    output char_out, char_valid, gnt, done, busy
  );
endinterface

// File: rtl/msg_rom.sv
// msg_rom: combinational (sel, index) -> ASCII character lookup.
// Ports: sel_i message select, idx_i char index, char_o character.
module msg_rom
  import msg_sched_pkg::*;
(
  input  logic [1:0] sel_i,
  input  logic [3:0] idx_i,
  output logic [7:0] char_o
);

  assign char_o = is_guat(sel_i) ? GUAT_C[idx_i]
                                 : QUET_C[idx_i];

endmodule

// File: rtl/msg_sched.sv
// msg_sched: two-requester round-robin message streamer with gap.
// Ports: clk, reset (async high), bus (msg_sched_if.slave).
module msg_sched
  import msg_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  msg_sched_if.slave   bus
);

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [3:0] cnt_q, cnt_d;
  logic       prio_q, prio_d;

  logic       valid;
  logic       fire;
  logic       last;
  logic       gid;
  logic [7:0] rom_char;

  msg_rom u_rom (
    .sel_i  (sel_q),
    .idx_i  (idx_q),
    .char_o (rom_char)
  );

  assign valid = (state_q == SEND) && bus.en;
  assign fire  = valid && bus.char_ready;
  assign last  = idx_q == last_idx(sel_q);

  // prio_q names the requester that wins a tie.
  assign gid = (&bus.req) ? prio_q : bus.req[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en && (bus.req != 2'b00)) begin
          gnt_d   = gid ? 2'b10 : 2'b01;
          sel_d   = gid ? bus.sel_1 : bus.sel_0;
          prio_d  = ~gid;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (last) begin
            gnt_d   = '0;
            done_d  = gnt_q;
            idx_d   = '0;
            cnt_d   = '0;
            state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (bus.en) begin
          if (cnt_q == 4'(GAP_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.char_valid = valid;
  assign bus.char_out   = valid ? rom_char : 8'h00;
  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.busy       = state_q != IDLE;

endmodule

// File: doc/msg_sched.md
MSG_SCHED -- requirements
Module: msg_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 2, idle cycles inserted after each message (range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 en  input  1  global enable; low pauses the scheduler without losing state.
REQ-005 req  input  2  per-requester message request, level, held until matching done pulse.
REQ-006 sel_0  input  2  message select for requester 0.
REQ-007 sel_1  input  2  message select for requester 1.
REQ-008 char_ready  input  1  downstream accepts char_out when high with char_valid.
REQ-009 char_out  output  8  current ASCII character; 8'h00 when char_valid low.
REQ-010 char_valid  output  1  char_out holds a valid character.
REQ-011 gnt  output  2  one-hot grant, high for the whole transfer of the granted requester.
REQ-012 done  output  2  one-cycle pulse to the requester whose message just completed.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Message table: sel 2'b00/2'b11 -> "Guatemala" (9 chars, 47 75 61 74 65 6D 61 6C 61 hex); sel 2'b01/2'b10 -> "Quetzal" (7 chars, 51 75 65 74 7A 61 6C hex).
REQ-015 FSM states IDLE, SEND, GAP; reset state IDLE.
REQ-016 IDLE: when en=1 and req!=0, grant one requester, latch its sel, set index 0, go to SEND next cycle; otherwise remain.
REQ-017 Arbitration round-robin: if both request, grant the one not granted last; priority pointer resets to favour requester 0.
REQ-018 Grant latency: request visible at edge k in IDLE -> gnt and char_valid high after edge k.
REQ-019 SEND: char_valid=1 while en=1; index advances only on cycle where char_valid & char_ready.
REQ-020 char_out and index SHALL stay stable while char_valid=1 and char_ready=0.
REQ-021 Accept of last character (index = length-1): go to GAP (or IDLE if GAP_CYCLES=0), clear gnt, pulse done for the granted requester in the following cycle.
REQ-022 GAP: 4-bit counter counts GAP_CYCLES cycles with en=1, then IDLE; no grant during GAP.
REQ-023 en=0 in SEND: char_valid=0, char_out=0, index held; resume at same index when en returns.
REQ-024 en=0 in GAP: counter frozen.
REQ-025 Latched sel is used for the whole message; sel changes after grant ignored.
REQ-026 Requester dropping req mid-message: message still completes and done still pulses (no abort).
REQ-027 Requester re-asserting req after done is served as a new request under REQ-017.

Reset
REQ-028 On reset: state IDLE, gnt=0, done=0, char_valid=0, char_out=8'h00, busy=0, index=0, gap counter=0, priority pointer to requester 0.
REQ-029 Reset asserted mid-message aborts it with no done pulse; after release, pending requests are re-arbitrated from IDLE.

Structure
REQ-030 Shared package holds state enum, message length constants (9, 7) and ASCII character tables.
REQ-031 One sub-module msg_rom: combinational (sel, index) -> char lookup; FSM, arbiter and counters in msg_sched.

Verification
REQ-032 req=01, sel_0=00, char_ready=1, en=1 -> gnt=01 next cycle, 9 chars "Guatemala" on consecutive cycles, done=01 pulse, then 2 GAP cycles with busy=1.
REQ-033 req=11 held, sel_0=00, sel_1=01 -> order: Guatemala (gnt=01), gap, Quetzal (gnt=10), gap, Guatemala (gnt=01).
REQ-034 char_ready low 3 cycles at index 4 of "Quetzal" -> char_out stays 8'h7A with char_valid=1 for those cycles, no skipped/duplicated character.
REQ-035 en low 2 cycles at index 3 -> char_valid=0 for 2 cycles, stream resumes with 8'h74 (Guatemala) and completes normally.
REQ-036 reset pulse at index 5 -> all outputs zero immediately, no done; after release with req=01 held, message restarts at index 0.
